// File: rtl/draw_pkg.sv
// Shared types and constants for the sprite drawing datapath.
// Screen geometry defaults and the 3-bit palette live here.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ERASE,
    DRAW,
    DONE
  } state_e;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int COLOR_W = 3;

  localparam logic [COLOR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOR_W-1:0] CYAN = 3'b011;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/draw_sprite_mover_raster_counter.sv
// Column-inner, row-outer raster counter for one sprite pass.
// col/row present the position for the coming cycle; last flags the final pixel.
module raster_counter
  import draw_pkg::*;
#(
  parameter int W = 9,
  parameter int H = 5,
  localparam int CW = idx_w(W),
  localparam int RW = idx_w(H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_q == CW'(W - 1));
  assign row_end = (row_q == RW'(H - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_d;
  assign row  = row_d;
  assign last = col_end && row_end;

endmodule

// File: rtl/draw_sprite_mover.sv
// Draws a fixed-size sprite at one of NUM_POS lanes, erasing the old one on a move.
// Outputs are registered from next-state values so pixel 0 shows the cycle after Start.
module draw_sprite_mover
  import draw_pkg::*;
#(
  parameter int SPR_W = 9,
  parameter int SPR_H = 5,
  parameter int NUM_POS = 4,
  parameter logic [8*NUM_POS-1:0] X_TABLE = {8'd132, 8'd78, 8'd24, 8'd6},
  parameter int Y_ORIGIN = 102,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  localparam int PW = idx_w(NUM_POS),
  localparam int CW = idx_w(SPR_W),
  localparam int RW = idx_w(SPR_H)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [PW-1:0]      PosSel,
  input  logic               Erase,
  input  logic [COLOR_W-1:0] FgColor,
  input  logic [COLOR_W-1:0] BgColor,
  output logic               Busy,
  output logic [7:0]         XOut,
  output logic [6:0]         YOut,
  output logic [COLOR_W-1:0] Color,
  output logic               Plot,
  output logic               DoneDrawing
);

  state_e             state_q, state_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic [PW-1:0]      last_pos_q, last_pos_d;
  logic               last_valid_q, last_valid_d;
  logic               erase_q, erase_d;
  logic [COLOR_W-1:0] fg_q, fg_d;
  logic [COLOR_W-1:0] bg_q, bg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               plot_q, plot_d;
  logic [7:0]         x_q, x_d;
  logic [6:0]         y_q, y_d;
  logic [COLOR_W-1:0] color_q, color_d;

  logic               cnt_clr;
  logic               cnt_en;
  logic               cnt_last;
  logic [CW-1:0]      col_n;
  logic [RW-1:0]      row_n;
  logic [PW-1:0]      sel_c;
  logic [PW-1:0]      pass_pos;
  logic [7:0]         base;
  logic [8:0]         x9;
  logic [7:0]         y8;
  logic               in_pass;

  raster_counter #(
    .W(SPR_W),
    .H(SPR_H)
  ) u_cnt (
    .clk (Clock),
    .rst (Reset),
    .clr (cnt_clr),
    .en  (cnt_en),
    .col (col_n),
    .row (row_n),
    .last(cnt_last)
  );

  always_comb begin
    sel_c = PosSel;
    if (int'(PosSel) > NUM_POS - 1) sel_c = PW'(NUM_POS - 1);
  end

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    erase_d      = erase_q;
    fg_d         = fg_q;
    bg_d         = bg_q;
    last_pos_d   = last_pos_q;
    last_valid_d = last_valid_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          pos_d   = sel_c;
          erase_d = Erase;
          fg_d    = FgColor;
          bg_d    = BgColor;
          cnt_clr = 1'b1;
          if (Erase) begin
            state_d = last_valid_q ? ERASE : DONE;
          end else if (last_valid_q && (sel_c != last_pos_q)) begin
            state_d = ERASE;
          end else begin
            state_d = DRAW;
          end
        end
      end
      ERASE: begin
        cnt_en = 1'b1;
        if (cnt_last) state_d = erase_q ? DONE : DRAW;
      end
      DRAW: begin
        cnt_en = 1'b1;
        if (cnt_last) state_d = DONE;
      end
      DONE: begin
        state_d      = IDLE;
        last_valid_d = !erase_q;
        if (!erase_q) last_pos_d = pos_q;
      end
    endcase
  end

  // Pixel for the coming cycle: erase uses the remembered lane, draw the latched one.
  always_comb begin
    in_pass  = (state_d == ERASE) || (state_d == DRAW);
    pass_pos = (state_d == ERASE) ? last_pos_q : pos_d;
    base     = X_TABLE[8*int'(pass_pos) +: 8];
    x9       = {1'b0, base} + 9'(col_n);
    y8       = 8'(Y_ORIGIN) + 8'(row_n);
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    plot_d   = 1'b0;
    busy_d   = in_pass;
    done_d   = (state_d == DONE);
    if (in_pass) begin
      x_d     = x9[7:0];
      y_d     = y8[6:0];
      color_d = (state_d == ERASE) ? bg_d : fg_d;
      plot_d  = (x9 < 9'(SCREEN_W)) && (y8 < 8'(SCREEN_H));
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      erase_q      <= 1'b0;
      fg_q         <= CYAN;
      bg_q         <= BLACK;
      last_pos_q   <= '0;
      last_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      plot_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= BLACK;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      erase_q      <= erase_d;
      fg_q         <= fg_d;
      bg_q         <= bg_d;
      last_pos_q   <= last_pos_d;
      last_valid_q <= last_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      plot_q       <= plot_d;
      x_q          <= x_d;
      y_q          <= y_d;
      color_q      <= color_d;
    end
  end

  assign Busy        = busy_q;
  assign DoneDrawing = done_q;
  assign Plot        = plot_q;
  assign XOut        = x_q;
  assign YOut        = y_q;
  assign Color       = color_q;

endmodule

// File: doc/draw_sprite_mover.md
Name: draw_sprite_mover

Overview:
Parametrised successor to the single-character drawer. It rasterises a fixed-size rectangular sprite at one of NUM_POS lane positions on the 160x120, 3-bit-colour VGA framebuffer. It remembers the last drawn position, so a move request automatically erases the old sprite in the background colour before drawing the new one. It sits between the game FSM (Start/PosSel/Erase) and the VGA adapter write port (XOut/YOut/Color/Plot).

Parameters:
SPR_W, 9, sprite width in pixels (columns)
SPR_H, 5, sprite height in pixels (rows)
NUM_POS, 4, number of selectable lane positions
X_TABLE, {8'd132,8'd78,8'd24,8'd6}, packed 8-bit X origins; entry i sits at bits [8i+7:8i]
Y_ORIGIN, 102, top row of the sprite for every position
SCREEN_W, 160, framebuffer width, used for clipping
SCREEN_H, 120, framebuffer height, used for clipping

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
Start  in  1  request strobe; sampled only in IDLE
PosSel  in  max(1,$clog2(NUM_POS))  target position index, latched on an accepted Start
Erase  in  1  latched with Start; 1 = erase the current sprite only
FgColor  in  3  sprite colour, latched on an accepted Start
BgColor  in  3  background colour for erase passes, latched on an accepted Start
Busy  out  1  high from the cycle after an accepted Start until Done
XOut  out  8  pixel X to the VGA adapter
YOut  out  7  pixel Y to the VGA adapter
Color  out  3  pixel colour
Plot  out  1  write enable for the current XOut/YOut/Color
DoneDrawing  out  1  one-cycle pulse when the request completes

Behaviour:
- Reset (synchronous, active-high) sets:
  - all outputs to 0 and the state to IDLE
  - LastValid=0, LastPos=0
  - Reset takes priority over everything and aborts a pass in progress; no further Plot.
- States: IDLE, ERASE, DRAW, DONE.
- IDLE, Start=1: latch PosSel, Erase, FgColor and BgColor; clear the column/row counters; go to the first pass.
  - Erase=1: ERASE at LastPos if LastValid, else straight to DONE with no pixels.
  - Erase=0, LastValid=1, PosSel!=LastPos: ERASE at LastPos, then DRAW at PosSel.
  - Erase=0, otherwise (first draw, or same position): DRAW at PosSel only.
- Start outside IDLE is ignored (not queued).
- PosSel >= NUM_POS on Start is clamped to NUM_POS-1.
- Each pass takes exactly SPR_W*SPR_H cycles, one pixel per cycle, in raster order: column counter is inner (0..SPR_W-1), row counter is outer (0..SPR_H-1).
- All outputs are registered. The first pixel appears the cycle after Start is accepted:
  - XOut = X_TABLE[pos] + col, computed 9 bits wide
  - YOut = Y_ORIGIN + row, computed 8 bits wide
  - Color = BgColor in ERASE, FgColor in DRAW
- Clipping: if the 9-bit X >= SCREEN_W or the 8-bit Y >= SCREEN_H, force Plot=0. The counters still advance, so pass timing is constant.
- Outside pixel cycles Plot=0; XOut/YOut/Color hold their last value.
- ERASE to DRAW: no idle cycle; the counters restart at 0 in the cycle following the last erase pixel.
- End of request (last pixel of the final pass, or immediately in the empty-erase case):
  - go to DONE for one cycle, assert DoneDrawing=1 and Busy=0, then return to IDLE.
  - Start in the DONE cycle is ignored.
- LastPos/LastValid update in the DONE cycle:
  - after a DRAW pass: LastPos=drawn position, LastValid=1
  - after an erase-only request: LastValid=0
- Latency, Start accepted at cycle 0:
  - single pass: pixels at cycles 1..P, DoneDrawing at P+1 (P = SPR_W*SPR_H)
  - move: erase pixels at 1..P, draw pixels at P+1..2P, DoneDrawing at 2P+1

Decomposition:
- Shared package draw_pkg holds:
  - the state enum (IDLE/ERASE/DRAW/DONE)
  - SCREEN_W/SCREEN_H defaults
  - COLOR_W=3 and the colour constants (BLACK=3'b000, CYAN=3'b011)
- One natural sub-module: raster_counter (parameters W, H). It provides a clear/enable interface and col, row and last outputs. The mover instantiates it once and reuses it across passes.

Test Plan:
- Reset, then Start PosSel=0 FgColor=3'b011 -> Plot high for cycles 1..45; first pixel (6,102), last pixel (14,106), Color=3'b011; DoneDrawing pulses at cycle 46; Busy high for cycles 1..45.
- After that, Start PosSel=2 BgColor=0 -> 45 erase pixels, x 6..14 y 102..106, Color=0; then 45 draw pixels, x 78..86; DoneDrawing at cycle 91.
- Start PosSel=2 again -> draw-only, 45 pixels at x 78..86, Done at cycle 46; Start Erase=1 -> 45 pixels Color=BgColor at 78..86. A second Erase=1 request gives 0 pixels and Done at cycle 1.
- X_TABLE entry 155 -> Plot only for columns 0..4 (x 155..159), still 45 cycles, Done at cycle 46; Start pulses during Busy cause no extra pixels.
- Reset asserted at cycle 20 of a move -> Plot=0 and DoneDrawing=0 from the next cycle. A following Start PosSel=1 is draw-only at x 24..32 (LastValid was cleared).
- PosSel=7 with NUM_POS=4 -> draws at position 3 (x 132..140).
